lsu_dmem_master: RTL and testbench

- Load/store unit memory initiator: accepts one load/store request at a time from the execute stage and drives the data-memory port of the 2R1W RAM.
- Drives dmem_ren/raddr and dmem_wen/waddr/wmask/wdata; consumes dmem_rdata.
- Performs byte-lane alignment, 32-bit write-mask generation and load sign/zero extension.
- Returns a response over a valid/ready handshake.

---
 rtl/lsu_pkg.sv | 35 +++
 rtl/lsu_load_align.sv | 23 ++
 rtl/lsu_dmem_master.sv | 193 +++++++++++++++++++
 tb/tb_lsu_dmem_master.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the load/store unit memory path.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    RESP = 2'd3
  } lsu_state_e;

  function automatic logic [31:0] expand_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  // Byte enables for an access of the given size starting at lane 0.
  function automatic logic [3:0] size_to_be(input logic [1:0] size);
    logic [3:0] be;
    case (size)
      SZ_B:    be = 4'b0001;
      SZ_H:    be = 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shift the captured word pair down to the access offset, truncate to size, then extend.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] word_pair,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] rdata
);

  logic [31:0] shifted;

  always_comb begin
    shifted = word_pair[{offset, 3'b000} +: 32];
    case (size)
      SZ_B:    rdata = {{24{~is_unsigned & shifted[7]}}, shifted[7:0]};
      SZ_H:    rdata = {{16{~is_unsigned & shifted[15]}}, shifted[15:0]};
      default: rdata = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store unit data-memory initiator: one request at a time against the 2R1W RAM port.
// Define LSU_MISALIGN_SPLIT_EN to split misaligned half/word accesses into two word accesses.
module lsu_dmem_master
  import lsu_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] ADDR_MASK = 32'hFFFF_FFFC
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_wen,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            dmem_ren,
  output logic [XLEN-1:0] dmem_raddr,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            dmem_wen,
  output logic [XLEN-1:0] dmem_waddr,
  output logic [XLEN-1:0] dmem_wmask,
  output logic [XLEN-1:0] dmem_wdata
);

  lsu_state_e      state_q, state_d;
  logic            wen_q, wen_d;
  logic [1:0]      size_q, size_d;
  logic            unsigned_q, unsigned_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata0_q, rdata0_d;
  logic            err_q, err_d;

  logic            req_err;
  logic [3:0]      be_lo;
  logic [31:0]     wdata_lo;
  logic [63:0]     load_pair;
  logic [31:0]     load_data;

`ifdef LSU_MISALIGN_SPLIT_EN
  logic [XLEN-1:0] rdata1_q, rdata1_d;
  logic [7:0]      be_wide;
  logic [63:0]     wdata_wide;
  logic [3:0]      be_hi;
  logic [31:0]     wdata_hi;
  logic            need_split;

  assign req_err    = (req_size == 2'd3);
  // Lanes that spill past byte 3 belong to the following word.
  assign be_wide    = {4'b0000, size_to_be(size_q)} << addr_q[1:0];
  assign wdata_wide = {32'b0, wdata_q} << {addr_q[1:0], 3'b000};
  assign be_lo      = be_wide[3:0];
  assign be_hi      = be_wide[7:4];
  assign wdata_lo   = wdata_wide[31:0];
  assign wdata_hi   = wdata_wide[63:32];
  assign need_split = |be_hi;
  assign load_pair  = {rdata1_q, rdata0_q};
`else
  logic misaligned;

  assign misaligned = ((req_size == SZ_H) && req_addr[0]) ||
                      ((req_size == SZ_W) && (req_addr[1:0] != 2'b00));
  assign req_err    = (req_size == 2'd3) || misaligned;
  assign be_lo      = size_to_be(size_q) << addr_q[1:0];
  assign wdata_lo   = wdata_q << {addr_q[1:0], 3'b000};
  assign load_pair  = {32'b0, rdata0_q};
`endif

  lsu_load_align u_load_align (
    .word_pair   (load_pair),
    .offset      (addr_q[1:0]),
    .size        (size_q),
    .is_unsigned (unsigned_q),
    .rdata       (load_data)
  );

  assign resp_err   = (state_q == RESP) && err_q;
  assign resp_rdata = ((state_q == RESP) && !err_q && !wen_q) ? load_data : '0;

  always_comb begin
    state_d    = state_q;
    wen_d      = wen_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    err_d      = err_q;
`ifdef LSU_MISALIGN_SPLIT_EN
    rdata1_d   = rdata1_q;
`endif
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    dmem_ren   = 1'b0;
    dmem_wen   = 1'b0;
    dmem_raddr = '0;
    dmem_waddr = '0;
    dmem_wmask = '0;
    dmem_wdata = '0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          wen_d      = req_wen;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          err_d      = req_err;
          state_d    = req_err ? RESP : ACC0;
        end
      end

      ACC0: begin
        if (wen_q) begin
          dmem_wen   = 1'b1;
          dmem_waddr = addr_q & ADDR_MASK;
          dmem_wmask = expand_mask(be_lo);
          dmem_wdata = wdata_lo;
        end else begin
          dmem_ren   = 1'b1;
          dmem_raddr = addr_q & ADDR_MASK;
          rdata0_d   = dmem_rdata;
        end
        state_d = RESP;
`ifdef LSU_MISALIGN_SPLIT_EN
        if (need_split) state_d = ACC1;
`endif
      end

      ACC1: begin
`ifdef LSU_MISALIGN_SPLIT_EN
        if (wen_q) begin
          dmem_wen   = 1'b1;
          dmem_waddr = (addr_q & ADDR_MASK) + 32'd4;
          dmem_wmask = expand_mask(be_hi);
          dmem_wdata = wdata_hi;
        end else begin
          dmem_ren   = 1'b1;
          dmem_raddr = (addr_q & ADDR_MASK) + 32'd4;
          rdata1_d   = dmem_rdata;
        end
        state_d = RESP;
`else
        state_d = IDLE;
`endif
      end

      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      wen_q      <= 1'b0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      err_q      <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
      rdata1_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wen_q      <= wen_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      err_q      <= err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
      rdata1_q   <= rdata1_d;
`endif
    end
  end

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Scoreboard bench for lsu_dmem_master: stimulus pushes expected memory accesses and responses,
// monitors on the falling edge pop and compare them.
module tb_lsu_dmem_master;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        dmem_ren, dmem_wen;
  logic [31:0] dmem_raddr, dmem_rdata, dmem_waddr, dmem_wmask, dmem_wdata;

  logic [31:0] mem [0:15];
  int          cycle = 0;
  int          compared = 0;
  int          mismatched = 0;

  typedef struct {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] mask;
    logic [31:0] wdata;
    int          cycle;
  } memExp_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cycle;
  } respExp_t;

  memExp_t  memQ[$];
  respExp_t respQ[$];
  memExp_t  curMem;
  bit       respActive = 1'b0;
  bit       checkDeassert = 1'b0;

  lsu_dmem_master dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .dmem_ren     (dmem_ren),
    .dmem_raddr   (dmem_raddr),
    .dmem_rdata   (dmem_rdata),
    .dmem_wen     (dmem_wen),
    .dmem_waddr   (dmem_waddr),
    .dmem_wmask   (dmem_wmask),
    .dmem_wdata   (dmem_wdata)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cycle <= cycle + 1;

  // Small RAM model: combinational read, bit-masked write on the rising edge.
  assign dmem_rdata = dmem_ren ? mem[dmem_raddr[5:2]] : 32'h0;

  always @(posedge clock) begin
    if (dmem_wen)
      mem[dmem_waddr[5:2]] <= (mem[dmem_waddr[5:2]] & ~dmem_wmask) | (dmem_wdata & dmem_wmask);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %08h, expected %08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic reportFail(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: expected event did not occur as required (cycle %0d)", name, cycle);
  endtask

  // Memory port monitor: every access must match the oldest expected access.
  always @(negedge clock) begin
    if (reset && (dmem_ren || dmem_wen)) begin
      if (memQ.size() == 0) begin
        reportFail("unexpected dmem access");
      end else begin
        curMem = memQ.pop_front();
        checkOutput("dmem access cycle", 32'(cycle), 32'(curMem.cycle));
        checkOutput("dmem_wen", {31'b0, dmem_wen}, {31'b0, curMem.wen});
        checkOutput("dmem_ren", {31'b0, dmem_ren}, {31'b0, ~curMem.wen});
        if (curMem.wen) begin
          checkOutput("dmem_waddr", dmem_waddr, curMem.addr);
          checkOutput("dmem_wmask", dmem_wmask, curMem.mask);
          checkOutput("dmem_wdata", dmem_wdata, curMem.wdata);
        end else begin
          checkOutput("dmem_raddr", dmem_raddr, curMem.addr);
        end
      end
    end
  end

  // Response monitor: latency on first presentation, data held stable until the handshake.
  always @(negedge clock) begin
    if (!reset) begin
      respActive    = 1'b0;
      checkDeassert = 1'b0;
    end else if (checkDeassert) begin
      checkOutput("resp_valid after handshake", {31'b0, resp_valid}, 32'h0);
      checkDeassert = 1'b0;
    end else if (resp_valid) begin
      if (respQ.size() == 0) begin
        reportFail("unexpected response");
      end else begin
        if (!respActive) begin
          checkOutput("resp latency", 32'(cycle), 32'(respQ[0].cycle));
          respActive = 1'b1;
        end
        checkOutput("resp_rdata", resp_rdata, respQ[0].rdata);
        checkOutput("resp_err", {31'b0, resp_err}, {31'b0, respQ[0].err});
        checkOutput("req_ready in RESP", {31'b0, req_ready}, 32'h0);
        if (resp_ready) begin
          void'(respQ.pop_front());
          respActive    = 1'b0;
          checkDeassert = 1'b1;
        end
      end
    end
  end

  task automatic applyStimulus(input logic wen, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic expErr, input logic [31:0] expRdata,
                               input logic [31:0] expMask, input logic [31:0] expWdata);
    int       waitCycles;
    memExp_t  m;
    respExp_t r;
    req_valid    = 1'b1;
    req_wen      = wen;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    waitCycles   = 0;
    @(negedge clock);
    while (!req_ready && waitCycles < 50) begin
      @(negedge clock);
      waitCycles++;
    end
    if (!req_ready) begin
      reportFail("request accept timeout");
      req_valid = 1'b0;
      return;
    end
    if (!expErr) begin
      m.wen   = wen;
      m.addr  = {addr[31:2], 2'b00};
      m.mask  = expMask;
      m.wdata = expWdata;
      m.cycle = cycle + 1;
      memQ.push_back(m);
    end
    r.rdata = expRdata;
    r.err   = expErr;
    r.cycle = expErr ? cycle + 1 : cycle + 2;
    respQ.push_back(r);
    @(posedge clock);
    #1;
    req_valid = 1'b0;
  endtask

  initial begin
    int waitCycles;
    req_valid    = 1'b0;
    req_wen      = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_addr     = 32'h0;
    req_wdata    = 32'h0;
    resp_ready   = 1'b1;

    repeat (3) @(negedge clock);
    checkOutput("reset resp_valid", {31'b0, resp_valid}, 32'h0);
    checkOutput("reset resp_rdata", resp_rdata, 32'h0);
    checkOutput("reset resp_err", {31'b0, resp_err}, 32'h0);
    checkOutput("reset dmem_ren", {31'b0, dmem_ren}, 32'h0);
    checkOutput("reset dmem_wen", {31'b0, dmem_wen}, 32'h0);
    checkOutput("reset dmem_raddr", dmem_raddr, 32'h0);
    checkOutput("reset dmem_waddr", dmem_waddr, 32'h0);
    checkOutput("reset dmem_wmask", dmem_wmask, 32'h0);
    checkOutput("reset dmem_wdata", dmem_wdata, 32'h0);
    reset = 1'b1;
    #1;
    checkOutput("req_ready after reset", {31'b0, req_ready}, 32'h1);
    @(posedge clock);
    #1;

    // Stores and word load through lane steering.
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h8000_0013, 32'h0000_00AB, 1'b0, 32'h0, 32'hFF00_0000, 32'hAB00_0000);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0,         1'b0, 32'hABAD_BEEF, 32'h0, 32'h0);

    // Sign and zero extension from the word 0x80FF_7F01.
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h8000_0004, 32'h80FF_7F01, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h80FF_7F01);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h8000_0007, 32'h0, 1'b0, 32'hFFFF_FF80, 32'h0, 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h8000_0007, 32'h0, 1'b0, 32'h0000_0080, 32'h0, 32'h0);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h8000_0006, 32'h0, 1'b0, 32'hFFFF_80FF, 32'h0, 32'h0);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h8000_0004, 32'h0, 1'b0, 32'h0000_7F01, 32'h0, 32'h0);
    applyStimulus(1'b0, 2'd0, 1'b0, 32'h8000_0005, 32'h0, 1'b0, 32'h0000_007F, 32'h0, 32'h0);

    // Half stores into both halves of one word.
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h8000_0012, 32'h0000_1234, 1'b0, 32'h0, 32'hFFFF_0000, 32'h1234_0000);
    applyStimulus(1'b1, 2'd1, 1'b0, 32'h8000_0010, 32'hFFFF_5678, 1'b0, 32'h0, 32'h0000_FFFF, 32'hFFFF_5678);

    // Illegal accesses: error response, no memory activity.
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h8000_0002, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h8000_0001, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 2'd3, 1'b0, 32'h8000_0000, 32'h0, 1'b1, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h8000_0011, 32'h5555_5555, 1'b1, 32'h0, 32'h0, 32'h0);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h8000_0010, 32'h0, 1'b0, 32'h1234_5678, 32'h0, 32'h0);

    // Back-pressure: response held for five cycles.
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'h0, 1'b0, 32'h80FF_7F01, 32'h0, 32'h0);
    resp_ready = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    resp_ready = 1'b1;

    // Reset during the access cycle of a store must suppress the write.
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h8000_0020, 32'h1122_3344, 1'b0, 32'h0, 32'hFFFF_FFFF, 32'h1122_3344);
    req_valid = 1'b1;
    req_wen   = 1'b1;
    req_size  = 2'd2;
    req_addr  = 32'h8000_0020;
    req_wdata = 32'hCAFE_F00D;
    waitCycles = 0;
    @(negedge clock);
    while (!req_ready && waitCycles < 50) begin
      @(negedge clock);
      waitCycles++;
    end
    if (!req_ready) reportFail("reset-test accept timeout");
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    checkOutput("store wen in access cycle", {31'b0, dmem_wen}, 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("dmem_wen on reset", {31'b0, dmem_wen}, 32'h0);
    checkOutput("dmem_wmask on reset", dmem_wmask, 32'h0);
    checkOutput("resp_valid on reset", {31'b0, resp_valid}, 32'h0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("req_ready after reset release", {31'b0, req_ready}, 32'h1);
    checkOutput("resp_valid after reset release", {31'b0, resp_valid}, 32'h0);
    @(posedge clock);
    #1;
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h8000_0020, 32'h0, 1'b0, 32'h1122_3344, 32'h0, 32'h0);

    waitCycles = 0;
    while ((respQ.size() != 0 || memQ.size() != 0) && waitCycles < 20) begin
      @(posedge clock);
      waitCycles++;
    end
    if (respQ.size() != 0) reportFail("pending responses at end");
    if (memQ.size() != 0) reportFail("pending memory accesses at end");
    @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
